// File: rtl/traffic_pkg.sv
// Shared types and constants for the junction light-output safety monitor.
package traffic_pkg;

  localparam logic [2:0] LIGHT_GRN = 3'b001;
  localparam logic [2:0] LIGHT_YEL = 3'b010;
  localparam logic [2:0] LIGHT_RED = 3'b100;

  typedef enum logic [1:0] {
    GRN = 2'd1,
    YEL = 2'd2,
    RED = 2'd0
  } aspect_e;

  localparam logic [2:0] FC_NONE      = 3'd0;
  localparam logic [2:0] FC_ENCODING  = 3'd1;
  localparam logic [2:0] FC_PAIRING   = 3'd2;
  localparam logic [2:0] FC_CONFLICT  = 3'd3;
  localparam logic [2:0] FC_ILLEGAL   = 3'd4;
  localparam logic [2:0] FC_SHORT_YEL = 3'd5;
  localparam logic [2:0] FC_SHORT_GRN = 3'd6;
  localparam logic [2:0] FC_STUCK     = 3'd7;

  typedef enum logic [1:0] {
    ARM   = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } mon_state_e;

  // Malformed codes map to RED; the encoding check flags them separately.
  function automatic aspect_e light_to_aspect(input logic [2:0] light);
    aspect_e asp;
    case (light)
      LIGHT_GRN: asp = GRN;
      LIGHT_YEL: asp = YEL;
      default:   asp = RED;
    endcase
    return asp;
  endfunction

  function automatic logic light_valid(input logic [2:0] light);
    return (light == LIGHT_GRN) || (light == LIGHT_YEL) || (light == LIGHT_RED);
  endfunction

endpackage

// File: rtl/traffic_pair_timer.sv
// Per-pair aspect tracker: previous aspect, saturating run length, transition flags.
// TRAFFIC_MON_MIN_TIME_EN exposes the old-run details used by the min-time checks.
module traffic_pair_timer
  import traffic_pkg::*;
#(
  parameter int MAX_PHASE = 32,
  parameter int CNT_W     = $clog2(MAX_PHASE + 2)
) (
  input  logic             clk,
  input  logic             rst_a,
  input  logic             restart,
  input  logic [2:0]       light,
`ifdef TRAFFIC_MON_MIN_TIME_EN
  output logic             change,
  output logic [1:0]       old_aspect,
  output logic [CNT_W-1:0] old_run_len,
  output logic             old_partial,
`endif
  output logic             illegal,
  output logic             stuck
);

  localparam logic [CNT_W-1:0] RUN_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] RUN_SAT = CNT_W'(MAX_PHASE + 1);

  aspect_e          aspect_q, aspect_d, cur_aspect;
  logic [CNT_W-1:0] run_len_q, run_len_d;
  logic             aspect_change;

  always_comb begin
    cur_aspect    = light_to_aspect(light);
    aspect_change = !restart && (cur_aspect != aspect_q);
    aspect_d      = cur_aspect;
    run_len_d     = RUN_ONE;
    if (!restart && !aspect_change) begin
      run_len_d = (run_len_q == RUN_SAT) ? RUN_SAT : run_len_q + RUN_ONE;
    end
  end

  assign illegal = aspect_change &&
                   (((aspect_q == GRN) && (cur_aspect == RED)) ||
                    ((aspect_q == RED) && (cur_aspect == YEL)));
  assign stuck   = (run_len_d == RUN_SAT);

  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      aspect_q  <= RED;
      run_len_q <= '0;
    end else begin
      aspect_q  <= aspect_d;
      run_len_q <= run_len_d;
    end
  end

`ifdef TRAFFIC_MON_MIN_TIME_EN
  // The run in progress when arming started mid-phase, so its length is unknown.
  logic partial_q, partial_d;

  always_comb begin
    partial_d = partial_q;
    if (restart) begin
      partial_d = 1'b1;
    end else if (aspect_change) begin
      partial_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      partial_q <= 1'b1;
    end else begin
      partial_q <= partial_d;
    end
  end

  assign change      = aspect_change;
  assign old_aspect  = aspect_q;
  assign old_run_len = run_len_q;
  assign old_partial = partial_q;
`endif

endmodule

// File: rtl/traffic_conflict_monitor.sv
// Passive safety monitor for the 4-way junction light outputs; latches the first fault.
// Define TRAFFIC_MON_MIN_TIME_EN to enable the min-green / min-yellow checks (codes 6/5).
module traffic_conflict_monitor
  import traffic_pkg::*;
#(
`ifdef TRAFFIC_MON_MIN_TIME_EN
  parameter int MIN_GREEN  = 8,
  parameter int MIN_YELLOW = 4,
`endif
  parameter int MAX_PHASE  = 32,
  parameter int CNT_W      = $clog2(MAX_PHASE + 2)
) (
  input  logic       clk,
  input  logic       rst_a,
  input  logic [2:0] n_lights,
  input  logic [2:0] s_lights,
  input  logic [2:0] e_lights,
  input  logic [2:0] w_lights,
  input  logic       clr_fault,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic       flash_req,
  output logic       armed
);

  mon_state_e state_q, state_d;
  logic [2:0] code_q, code_d, code_now;
  logic       restart, seq_en;
  logic       bad_enc, pair_mis, conflict, all_red;

  // Index 0 tracks the N/S pair (from n), index 1 the E/W pair (from e).
  logic [1:0][2:0] pair_light;
  logic [1:0]      pair_illegal, pair_stuck;
  logic [1:0]      pair_short_grn, pair_short_yel;

  assign restart       = (state_q == ARM);
  assign seq_en        = (state_q == RUN);
  assign pair_light[0] = n_lights;
  assign pair_light[1] = e_lights;

  assign bad_enc  = !(light_valid(n_lights) && light_valid(s_lights) &&
                      light_valid(e_lights) && light_valid(w_lights));
  assign pair_mis = (n_lights != s_lights) || (e_lights != w_lights);
  assign conflict = ((n_lights != LIGHT_RED) || (s_lights != LIGHT_RED)) &&
                    ((e_lights != LIGHT_RED) || (w_lights != LIGHT_RED));
  assign all_red  = (n_lights == LIGHT_RED) && (s_lights == LIGHT_RED) &&
                    (e_lights == LIGHT_RED) && (w_lights == LIGHT_RED);

`ifdef TRAFFIC_MON_MIN_TIME_EN
  localparam logic [CNT_W-1:0] MIN_GRN_LEN = CNT_W'(MIN_GREEN);
  localparam logic [CNT_W-1:0] MIN_YEL_LEN = CNT_W'(MIN_YELLOW);

  logic [1:0]            pair_change, pair_partial;
  logic [1:0][1:0]       pair_old_aspect;
  logic [1:0][CNT_W-1:0] pair_old_len;
`endif

  for (genvar gi = 0; gi < 2; gi++) begin : g_pair
    traffic_pair_timer #(
      .MAX_PHASE (MAX_PHASE),
      .CNT_W     (CNT_W)
    ) u_timer (
      .clk         (clk),
      .rst_a       (rst_a),
      .restart     (restart),
      .light       (pair_light[gi]),
`ifdef TRAFFIC_MON_MIN_TIME_EN
      .change      (pair_change[gi]),
      .old_aspect  (pair_old_aspect[gi]),
      .old_run_len (pair_old_len[gi]),
      .old_partial (pair_partial[gi]),
`endif
      .illegal     (pair_illegal[gi]),
      .stuck       (pair_stuck[gi])
    );

`ifdef TRAFFIC_MON_MIN_TIME_EN
    // Any change out of yellow is Y->R or Y->G; both need a full yellow.
    assign pair_short_grn[gi] = pair_change[gi] && !pair_partial[gi] &&
                                (pair_old_aspect[gi] == GRN) &&
                                (light_to_aspect(pair_light[gi]) == YEL) &&
                                (pair_old_len[gi] < MIN_GRN_LEN);
    assign pair_short_yel[gi] = pair_change[gi] && !pair_partial[gi] &&
                                (pair_old_aspect[gi] == YEL) &&
                                (pair_old_len[gi] < MIN_YEL_LEN);
`else
    assign pair_short_grn[gi] = 1'b0;
    assign pair_short_yel[gi] = 1'b0;
`endif
  end

  always_comb begin
    code_now = FC_NONE;
    if (bad_enc) begin
      code_now = FC_ENCODING;
    end else if (pair_mis) begin
      code_now = FC_PAIRING;
    end else if (conflict) begin
      code_now = FC_CONFLICT;
    end else if (seq_en && (|pair_illegal)) begin
      code_now = FC_ILLEGAL;
    end else if (seq_en && (|pair_short_yel)) begin
      code_now = FC_SHORT_YEL;
    end else if (seq_en && (|pair_short_grn)) begin
      code_now = FC_SHORT_GRN;
    end else if (seq_en && (|pair_stuck)) begin
      code_now = FC_STUCK;
    end
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    case (state_q)
      ARM: begin
        if (code_now != FC_NONE) begin
          state_d = FAULT;
          code_d  = code_now;
        end else begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (code_now != FC_NONE) begin
          state_d = FAULT;
          code_d  = code_now;
        end
      end
      FAULT: begin
        if (clr_fault && all_red) begin
          state_d = ARM;
          code_d  = FC_NONE;
        end
      end
      default: begin
        state_d = ARM;
        code_d  = FC_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      state_q <= ARM;
      code_q  <= FC_NONE;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
    end
  end

  assign fault      = (state_q == FAULT);
  assign fault_code = code_q;
  assign flash_req  = fault;
  assign armed      = (state_q == RUN);

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Directed self-checking bench for traffic_conflict_monitor, one task per scenario.
module tb_traffic_conflict_monitor;

  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] R = 3'b100;

`ifdef TRAFFIC_MON_MIN_TIME_EN
  localparam logic [2:0] EXP_SHORT_Y = 3'd5;
  localparam logic [2:0] EXP_SHORT_G = 3'd6;
`else
  localparam logic [2:0] EXP_SHORT_Y = 3'd0;
  localparam logic [2:0] EXP_SHORT_G = 3'd0;
`endif

  logic       clk = 1'b0;
  logic       rst_a = 1'b0;
  logic [2:0] n_l = R, s_l = R, e_l = R, w_l = R;
  logic       clr = 1'b0;
  logic       fault, flash_req, armed;
  logic [2:0] fault_code;

  int errors = 0;
  int checks = 0;
  int sample = 0;

  always #5 clk = ~clk;

  traffic_conflict_monitor dut (
    .clk        (clk),
    .rst_a      (rst_a),
    .n_lights   (n_l),
    .s_lights   (s_l),
    .e_lights   (e_l),
    .w_lights   (w_l),
    .clr_fault  (clr),
    .fault      (fault),
    .fault_code (fault_code),
    .flash_req  (flash_req),
    .armed      (armed)
  );

  task automatic step(input logic [2:0] n, input logic [2:0] s, input logic [2:0] e,
                      input logic [2:0] w, input logic clr_in);
    n_l = n; s_l = s; e_l = e; w_l = w; clr = clr_in;
    @(posedge clk);
    #1;
    sample++;
    $display("sample %0d n=%b s=%b e=%b w=%b clr=%0d -> fault=%0d code=%0d flash=%0d armed=%0d",
             sample, n, s, e, w, clr_in, fault, fault_code, flash_req, armed);
  endtask

  task automatic pair(input logic [2:0] ns, input logic [2:0] ew);
    step(ns, ns, ew, ew, 1'b0);
  endtask

  task automatic do_reset();
    n_l = R; s_l = R; e_l = R; w_l = R; clr = 1'b0;
    @(negedge clk);
    rst_a = 1'b0;
    @(negedge clk);
    rst_a = 1'b1;
  endtask

  task automatic test_reset();
    n_l = R; s_l = R; e_l = R; w_l = R; clr = 1'b0;
    rst_a = 1'b0;
    #12;
    if ({fault, fault_code, flash_req, armed} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: got fault=%b code=%b flash=%b armed=%b want all 0",
               fault, fault_code, flash_req, armed);
    end
    checks++;
    @(negedge clk);
    rst_a = 1'b1;
    pair(G, R);
    pair(G, R);
    if (armed !== 1'b1) begin
      errors++;
      $display("FAIL reset_armed_second_edge: got %b want 1", armed);
    end
    checks++;
  endtask

  task automatic test_nominal();
    logic [2:0] ns_a, ew_a;
    int k;
    do_reset();
    k = 0;
    for (int c = 0; c < 3; c++) begin
      for (int t = 0; t < 48; t++) begin
        ns_a = (t < 8) ? G : (t < 12) ? Y : (t < 20) ? G : (t < 24) ? Y : R;
        ew_a = (t < 24) ? R : (t < 32) ? G : (t < 36) ? Y : (t < 44) ? G : Y;
        pair(ns_a, ew_a);
        if ({fault, fault_code} !== 4'b0) begin
          errors++;
          $display("FAIL nominal_nofault t=%0d: got fault=%b code=%0d want 0", k, fault, fault_code);
        end
        checks++;
        if (k >= 1) begin
          if (armed !== 1'b1) begin
            errors++;
            $display("FAIL nominal_armed t=%0d: got %b want 1", k, armed);
          end
          checks++;
        end
        k++;
      end
    end
  endtask

  task automatic test_conflict();
    do_reset();
    repeat (3) pair(G, R);
    step(G, G, G, G, 1'b0);
    if ({fault, flash_req, fault_code} !== {1'b1, 1'b1, 3'd3}) begin
      errors++;
      $display("FAIL conflict_edge: got fault=%b flash=%b code=%0d want 1 1 3", fault, flash_req, fault_code);
    end
    checks++;
    repeat (2) pair(G, R);
    if (fault_code !== 3'd3) begin
      errors++;
      $display("FAIL conflict_hold: got code=%0d want 3", fault_code);
    end
    checks++;
  endtask

  task automatic test_skipped_yellow();
    do_reset();
    repeat (8) pair(G, R);
    if (fault !== 1'b0) begin
      errors++;
      $display("FAIL skipyel_before: got fault=%b want 0", fault);
    end
    checks++;
    pair(R, G);
    if ({fault, fault_code} !== {1'b1, 3'd4}) begin
      errors++;
      $display("FAIL skipyel_code: got fault=%b code=%0d want 1 4", fault, fault_code);
    end
    checks++;
  endtask

  task automatic test_short_yellow();
    do_reset();
    repeat (8) pair(G, R);
    repeat (2) pair(Y, R);
    if (fault !== 1'b0) begin
      errors++;
      $display("FAIL shortyel_before: got fault=%b want 0", fault);
    end
    checks++;
    pair(R, R);
    if ({fault, fault_code} !== {(EXP_SHORT_Y != 3'd0), EXP_SHORT_Y}) begin
      errors++;
      $display("FAIL shortyel_code: got fault=%b code=%0d want code %0d", fault, fault_code, EXP_SHORT_Y);
    end
    checks++;
  endtask

  task automatic test_short_green();
    do_reset();
    repeat (8) pair(R, G);
    repeat (4) pair(R, Y);
    repeat (3) pair(G, R);
    if (fault !== 1'b0) begin
      errors++;
      $display("FAIL shortgrn_before: got fault=%b code=%0d want 0", fault, fault_code);
    end
    checks++;
    pair(Y, R);
    if ({fault, fault_code} !== {(EXP_SHORT_G != 3'd0), EXP_SHORT_G}) begin
      errors++;
      $display("FAIL shortgrn_code: got fault=%b code=%0d want code %0d", fault, fault_code, EXP_SHORT_G);
    end
    checks++;
  endtask

  task automatic test_partial_exempt();
    do_reset();
    repeat (2) pair(G, R);
    repeat (4) pair(Y, R);
    pair(R, R);
    if ({fault, fault_code} !== 4'b0) begin
      errors++;
      $display("FAIL partial_exempt: got fault=%b code=%0d want 0", fault, fault_code);
    end
    checks++;
  endtask

  task automatic test_priority();
    logic [2:0] bad;
    bad = 3'b011;
    do_reset();
    pair(G, R);
    step(bad, G, G, G, 1'b0);
    if (fault_code !== 3'd1) begin
      errors++;
      $display("FAIL priority_code: got %0d want 1", fault_code);
    end
    checks++;
  endtask

  task automatic test_pairing();
    do_reset();
    pair(G, R);
    step(G, R, R, R, 1'b0);
    if (fault_code !== 3'd2) begin
      errors++;
      $display("FAIL pairing_code: got %0d want 2", fault_code);
    end
    checks++;
  endtask

  task automatic test_encoding_in_arm();
    logic [2:0] dark;
    dark = 3'b000;
    do_reset();
    step(dark, dark, R, R, 1'b0);
    if ({fault, fault_code} !== {1'b1, 3'd1}) begin
      errors++;
      $display("FAIL arm_encoding: got fault=%b code=%0d want 1 1", fault, fault_code);
    end
    checks++;
  endtask

  task automatic test_clr_in_run();
    do_reset();
    pair(R, R);
    step(R, R, R, R, 1'b1);
    if ({fault, armed} !== 2'b01) begin
      errors++;
      $display("FAIL clr_in_run: got fault=%b armed=%b want 0 1", fault, armed);
    end
    checks++;
  endtask

  task automatic test_stuck_clear();
    do_reset();
    repeat (32) pair(G, R);
    if (fault !== 1'b0) begin
      errors++;
      $display("FAIL stuck_32: got fault=%b code=%0d want 0", fault, fault_code);
    end
    checks++;
    pair(G, R);
    if ({fault, fault_code} !== {1'b1, 3'd7}) begin
      errors++;
      $display("FAIL stuck_33: got fault=%b code=%0d want 1 7", fault, fault_code);
    end
    checks++;
    step(G, G, R, R, 1'b1);
    if ({fault, fault_code} !== {1'b1, 3'd7}) begin
      errors++;
      $display("FAIL clr_not_red: got fault=%b code=%0d want 1 7", fault, fault_code);
    end
    checks++;
    step(R, R, R, R, 1'b1);
    if ({fault, fault_code, armed} !== 5'b0) begin
      errors++;
      $display("FAIL clr_all_red: got fault=%b code=%0d armed=%b want 0 0 0", fault, fault_code, armed);
    end
    checks++;
    pair(R, R);
    if ({fault, armed} !== 2'b01) begin
      errors++;
      $display("FAIL rearm: got fault=%b armed=%b want 0 1", fault, armed);
    end
    checks++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    pair(G, R);
    step(G, G, G, G, 1'b0);
    #2;
    rst_a = 1'b0;
    #1;
    if ({fault, fault_code, flash_req, armed} !== 6'b0) begin
      errors++;
      $display("FAIL async_reset: got fault=%b code=%0d flash=%b armed=%b want all 0",
               fault, fault_code, flash_req, armed);
    end
    checks++;
    @(negedge clk);
    rst_a = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_nominal();
    test_conflict();
    test_skipped_yellow();
    test_short_yellow();
    test_short_green();
    test_partial_exempt();
    test_priority();
    test_pairing();
    test_encoding_in_arm();
    test_clr_in_run();
    test_stuck_clear();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
